// File: rtl/sextium_io_unit.sv
// I/O port unit for the Sextium III io_bus: an RX FIFO feeds core reads, a TX FIFO drains core writes.
// Every access completes in its strobe cycle; bad accesses raise sticky error flags.
module sextium_io_unit #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    inout  wire  [WIDTH-1:0]      io_bus,
    input  logic                  io_read,
    input  logic                  io_write,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [2:0]            io_err,
    input  logic                  err_clear
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_rx_mem [0:DEPTH-1];
    logic [WIDTH-1:0]      r_tx_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;
    logic [DEPTH_LOG2:0]   r_rx_cnt, r_tx_cnt;
    logic [2:0]            r_err;

    logic w_rd_op, w_wr_op, w_coll;
    logic w_rx_empty, w_rx_push, w_rx_pop, w_rx_unf;
    logic w_tx_full, w_tx_push, w_tx_pop, w_tx_ovf;
    logic [2:0] w_err_set;

    // A strobe pair is a collision and touches neither FIFO.
    assign w_rd_op = io_read & ~io_write;
    assign w_wr_op = io_write & ~io_read;
    assign w_coll  = io_read & io_write;

    assign w_rx_empty = (r_rx_cnt == '0);
    assign in_ready   = (r_rx_cnt != CNT_FULL);
    assign w_rx_push  = in_valid & in_ready;
    assign w_rx_pop   = w_rd_op & ~w_rx_empty;
    assign w_rx_unf   = w_rd_op & w_rx_empty;

    // A pop in the same cycle frees the slot, so a write to a full TX FIFO still lands.
    assign w_tx_full  = (r_tx_cnt == CNT_FULL);
    assign out_valid  = (r_tx_cnt != '0);
    assign w_tx_pop   = out_valid & out_ready;
    assign w_tx_push  = w_wr_op & (~w_tx_full | w_tx_pop);
    assign w_tx_ovf   = w_wr_op & w_tx_full & ~w_tx_pop;

    assign w_err_set = {w_coll, w_tx_ovf, w_rx_unf};

    assign io_bus   = w_rd_op ? (w_rx_empty ? '0 : r_rx_mem[r_rx_rd]) : 'z;
    assign out_data = out_valid ? r_tx_mem[r_tx_rd] : '0;
    assign rx_count = r_rx_cnt;
    assign tx_count = r_tx_cnt;
    assign io_err   = r_err;

    // Storage arrays carry no reset; the counts alone decide what is visible.
    always_ff @(posedge clock) begin
        if (w_rx_push) r_rx_mem[r_rx_wr] <= in_data;
        if (w_tx_push) r_tx_mem[r_tx_wr] <= io_bus;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
            r_err    <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
                2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
                default: r_rx_cnt <= r_rx_cnt;
            endcase

            if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
                2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
                default: r_tx_cnt <= r_tx_cnt;
            endcase

            // A flag raised during a clear cycle survives the clear.
            r_err <= (err_clear ? 3'b000 : r_err) | w_err_set;
        end
    end
endmodule

// File: tb/tb_sextium_io_unit.sv
// Scoreboard bench for sextium_io_unit: RX/TX queues model both FIFOs, a shadow register models io_err.
module tb_sextium_io_unit;
    logic        clock;
    logic        reset;
    wire  [15:0] io_bus;
    logic        io_read, io_write;
    logic [15:0] in_data;
    logic        in_valid, in_ready;
    logic [15:0] out_data;
    logic        out_valid, out_ready;
    logic [3:0]  rx_count, tx_count;
    logic [2:0]  io_err;
    logic        err_clear;

    logic        tb_en;
    logic [15:0] tb_drv;
    assign io_bus = tb_en ? tb_drv : 'z;

    sextium_io_unit dut (
        .clock(clock), .reset(reset), .io_bus(io_bus),
        .io_read(io_read), .io_write(io_write),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .rx_count(rx_count), .tx_count(tx_count),
        .io_err(io_err), .err_clear(err_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];
    logic [2:0]  err_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, check combinational outputs, update scoreboard, clock, check registered state.
    task automatic step(input bit rd, input bit wr, input bit iv, input logic [15:0] d,
                        input bit ordy, input bit clr, input logic [15:0] busv);
        int rx_n, tx_n;
        logic [2:0]  set;
        logic [15:0] exp;
        io_read = rd; io_write = wr; in_valid = iv; in_data = d;
        out_ready = ordy; err_clear = clr; tb_drv = busv; tb_en = wr;
        #1;
        rx_n = rx_q.size();
        tx_n = tx_q.size();
        set  = 3'b000;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rx_n != 8});
        if (rd && !wr) begin
            if (rx_n > 0) exp = rx_q.pop_front();
            else begin exp = 16'h0000; set[0] = 1'b1; end
            chk("rd_bus", {16'd0, io_bus}, {16'd0, exp});
        end
        if (rd && wr) begin
            set[2] = 1'b1;
            chk("coll_bus", {16'd0, io_bus}, {16'd0, busv});
        end
        if (ordy && tx_n > 0) begin
            exp = tx_q.pop_front();
            chk("tx_out", {16'd0, out_data}, {16'd0, exp});
        end
        if (iv && rx_n < 8) rx_q.push_back(d);
        if (wr && !rd) begin
            if (tx_n < 8 || (ordy && tx_n > 0)) tx_q.push_back(busv);
            else set[1] = 1'b1;
        end
        err_m = (clr ? 3'b000 : err_m) | set;
        @(posedge clock);
        #1;
        io_read = 0; io_write = 0; in_valid = 0; err_clear = 0; out_ready = 0; tb_en = 0;
        chk("rx_count", {28'd0, rx_count}, rx_q.size());
        chk("tx_count", {28'd0, tx_count}, tx_q.size());
        chk("io_err", {29'd0, io_err}, {29'd0, err_m});
        chk("out_valid", {31'd0, out_valid}, {31'd0, tx_q.size() != 0});
        chk("out_data", {16'd0, out_data}, (tx_q.size() != 0) ? {16'd0, tx_q[0]} : 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rx_count"}, {28'd0, rx_count}, 32'd0);
        chk({tag, "_tx_count"}, {28'd0, tx_count}, 32'd0);
        chk({tag, "_io_err"}, {29'd0, io_err}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    endtask

    initial begin
        reset = 0; io_read = 0; io_write = 0; in_valid = 0; in_data = 0;
        out_ready = 0; err_clear = 0; tb_en = 0; tb_drv = 0; err_m = 3'b000;
        #12;
        chk_reset_state("por");
        reset = 1;
        @(posedge clock); #1;

        // 1: two pushes then two zero-latency reads
        step(0, 0, 1, 16'h1234, 0, 0, 0);
        step(0, 0, 1, 16'hABCD, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // 2: underflow, clear, then read during clear keeps the flag
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // 3: nine writes into an 8-deep TX with a stalled consumer, then drain
        for (int i = 1; i <= 9; i++) step(0, 1, 0, 0, 0, 0, i[15:0]);
        chk("tx_full_head", {16'd0, out_data}, 32'd1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // 3b: push+pop on a full TX is accepted
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 16'h0100 + i[15:0]);
        step(0, 1, 0, 0, 1, 0, 16'h0BEE);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0, 0);

        // 4: fill RX, push while full with a read, then stream 20 words through with wrap
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'hA000 + i[15:0], 0, 0, 0);
        chk("in_ready_full", {31'd0, in_ready}, 32'd0);
        step(1, 0, 1, 16'hDEAD, 0, 0, 0);
        for (int i = 8; i < 20; i++) step(1, 0, 1, 16'hA000 + i[15:0], 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0);

        // 5: collision with an external bus driver
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 16'h7777, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 16'h5555);
        step(1, 0, 0, 0, 0, 1, 0);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'hC000 + i[15:0], 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 16'hD000 + i[15:0]);
        chk("pre_rst_rx", {28'd0, rx_count}, 32'd5);
        chk("pre_rst_tx", {28'd0, tx_count}, 32'd3);
        #2;
        reset = 0;
        #1;
        chk_reset_state("async");
        rx_q.delete();
        tx_q.delete();
        err_m = 3'b000;
        #1;
        reset = 1;
        @(posedge clock); #1;
        step(1, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
